// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter (ALU vs load unit) with pending-write scoreboard.
// Define RR_ARB_EN for round-robin arbitration; otherwise the load unit has fixed priority.
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_enc,
  input  logic [4:0]      rs2_enc,
  output logic            hazard,
  output logic            write_enable,
  output logic [4:0]      reg_enc_write,
  output logic [XLEN-1:0] reg_w,
  output logic [31:0]     busy
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  grant_e          last_grant_q, last_grant_d;
  logic            we_q, we_d;
  logic [4:0]      wa_q, wa_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [31:0]     busy_q, busy_d;

  logic            alu_sel_s;
  logic            lsu_sel_s;
  logic            xfer_s;
  logic [4:0]      sel_rd_s;
  logic [XLEN-1:0] sel_data_s;
  logic            hazard_s;
  logic            set_s;

  // Arbitration between the two write-back requesters
  always_comb begin
    alu_sel_s = 1'b0;
    lsu_sel_s = 1'b0;
    if (alu_valid && lsu_valid) begin
`ifdef RR_ARB_EN
      if (last_grant_q == GRANT_ALU) begin
        lsu_sel_s = 1'b1;
      end else begin
        alu_sel_s = 1'b1;
      end
`else
      lsu_sel_s = 1'b1;
`endif
    end else if (alu_valid) begin
      alu_sel_s = 1'b1;
    end else if (lsu_valid) begin
      lsu_sel_s = 1'b1;
    end else begin
      alu_sel_s = 1'b0;
      lsu_sel_s = 1'b0;
    end
  end

  assign xfer_s = alu_sel_s | lsu_sel_s;

  // Select the granted request's destination and data
  always_comb begin
    case ({lsu_sel_s, alu_sel_s})
      2'b01:   begin sel_rd_s = alu_rd; sel_data_s = alu_data; end
      2'b10:   begin sel_rd_s = lsu_rd; sel_data_s = lsu_data; end
      default: begin sel_rd_s = 5'd0;   sel_data_s = {XLEN{1'b0}}; end
    endcase
  end

  // busy_q[0] is never set, so x0 cannot raise a hazard
  assign hazard_s = busy_q[rs1_enc] | busy_q[rs2_enc] | (issue_valid & busy_q[issue_rd]);
  assign set_s    = issue_valid & (issue_rd != 5'd0) & ~hazard_s;

  // Next-state for write port, arbiter memory and scoreboard
  always_comb begin
    we_d         = xfer_s & (sel_rd_s != 5'd0);
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    if (xfer_s) begin
      wa_d         = sel_rd_s;
      wd_d         = sel_data_s;
      last_grant_d = lsu_sel_s ? GRANT_LSU : GRANT_ALU;
    end else begin
      wa_d = wa_q;
      wd_d = wd_q;
    end
    if (we_q) begin
      busy_d[wa_q] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    // Set after clear so an issue to the register being written back wins
    if (set_s) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GRANT_ALU;
      we_q         <= 1'b0;
      wa_q         <= 5'd0;
      wd_q         <= {XLEN{1'b0}};
      busy_q       <= 32'd0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_ready     = alu_sel_s;
  assign lsu_ready     = lsu_sel_s;
  assign hazard        = hazard_s;
  assign write_enable  = we_q;
  assign reg_enc_write = wa_q;
  assign reg_w         = wd_q;
  assign busy          = busy_q;

endmodule
